// File: rtl/pkt_buf_pkg.sv
// Shared definitions for the single-packet buffer: default widths and the read FSM states.
package pkt_buf_pkg;

  localparam int unsigned BufAwidth = 4;
  localparam int unsigned BufDwidth = 16;

  typedef enum logic [1:0] {
    StIdle,
    StRead,
    StClr
  } rd_state_e;

endpackage

// File: rtl/pkt_out_fifo.sv
// Two-entry synchronous FIFO holding output words with their sop/eop flags.
module pkt_out_fifo
  import pkt_buf_pkg::*;
#(
  parameter int unsigned Width = BufDwidth + 2
) (
  input  logic             clk_i,
  input  logic             srst_i,
  input  logic             push_i,
  input  logic [Width-1:0] wdata_i,
  input  logic             pop_i,
  output logic [Width-1:0] rdata_o,
  output logic             empty_o,
  output logic             full_o,
  output logic [1:0]       usedw_o
);

  logic [Width-1:0] mem_q [2];
  logic [Width-1:0] mem_d [2];
  logic             wr_ptr_q, wr_ptr_d;
  logic             rd_ptr_q, rd_ptr_d;
  logic [1:0]       cnt_q, cnt_d;
  logic             do_push, do_pop;

  always_comb begin
    do_pop   = pop_i && (cnt_q != 2'd0);
    // A push into a full FIFO is only legal when the head leaves in the same cycle.
    do_push  = push_i && ((cnt_q != 2'd2) || do_pop);
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = wdata_i;
      wr_ptr_d        = ~wr_ptr_q;
    end
    if (do_pop) begin
      rd_ptr_d = ~rd_ptr_q;
    end
    cnt_d = cnt_q + {1'b0, do_push} - {1'b0, do_pop};
  end

  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      cnt_q    <= 2'd0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  assign rdata_o = mem_q[rd_ptr_q];
  assign empty_o = (cnt_q == 2'd0);
  assign full_o  = (cnt_q == 2'd2);
  assign usedw_o = cnt_q;

endmodule

// File: rtl/pkt_rd_ctrl.sv
// Read-side controller: streams a stored packet out of the buffer RAM with sop/eop framing
// under ready backpressure, then pulses clr_o back to the write controller.
module pkt_rd_ctrl
  import pkt_buf_pkg::*;
#(
  parameter int unsigned AWIDTH = BufAwidth,
  parameter int unsigned DWIDTH = BufDwidth
) (
  input  logic              clk_i,
  input  logic              srst_i,
  input  logic              busy_i,
  input  logic [AWIDTH-1:0] wrcnt_i,
  output logic              clr_o,
  output logic              rden_o,
  output logic [AWIDTH-1:0] rdaddr_o,
  input  logic [DWIDTH-1:0] rddata_i,
  output logic [DWIDTH-1:0] data_o,
  output logic              val_o,
  output logic              sop_o,
  output logic              eop_o,
  input  logic              ready_i
);

  localparam logic [AWIDTH:0] CntOne  = 1;
  localparam logic [AWIDTH:0] CntFull = {1'b1, {AWIDTH{1'b0}}};

  rd_state_e       state_q, state_d;
  logic [AWIDTH:0] len_q, len_d;
  logic [AWIDTH:0] issued_q, issued_d;
  logic [AWIDTH:0] xfer_cnt_q, xfer_cnt_d;
  logic            rd_pend_q, rd_pend_d;
  logic            pend_sop_q, pend_sop_d;
  logic            pend_eop_q, pend_eop_d;

  logic              xfer, credit, rden, clr;
  logic              fifo_empty, fifo_full;
  logic [1:0]        fifo_usedw;
  logic [DWIDTH+1:0] fifo_head;

  assign xfer = !fifo_empty && ready_i;

  // Occupancy plus in-flight read may reach 2 only if a word leaves this cycle.
  always_comb begin
    if (fifo_full) begin
      credit = xfer && !rd_pend_q;
    end else begin
      credit = !(fifo_usedw[0] && rd_pend_q) || xfer;
    end
  end

  always_comb begin
    state_d    = state_q;
    len_d      = len_q;
    issued_d   = issued_q;
    xfer_cnt_d = xfer_cnt_q;
    rd_pend_d  = 1'b0;
    pend_sop_d = pend_sop_q;
    pend_eop_d = pend_eop_q;
    rden       = 1'b0;
    clr        = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (busy_i) begin
          len_d      = (wrcnt_i == '0) ? CntFull : {1'b0, wrcnt_i};
          issued_d   = '0;
          xfer_cnt_d = '0;
          state_d    = StRead;
        end
      end
      StRead: begin
        if ((issued_q < len_q) && credit) begin
          rden       = 1'b1;
          issued_d   = issued_q + CntOne;
          rd_pend_d  = 1'b1;
          pend_sop_d = (issued_q == '0);
          pend_eop_d = (issued_q == len_q - CntOne);
        end
        if (xfer) begin
          xfer_cnt_d = xfer_cnt_q + CntOne;
          if (xfer_cnt_q == len_q - CntOne) begin
            state_d = StClr;
          end
        end
      end
      StClr: begin
        clr     = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      state_q    <= StIdle;
      len_q      <= '0;
      issued_q   <= '0;
      xfer_cnt_q <= '0;
      rd_pend_q  <= 1'b0;
      pend_sop_q <= 1'b0;
      pend_eop_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      issued_q   <= issued_d;
      xfer_cnt_q <= xfer_cnt_d;
      rd_pend_q  <= rd_pend_d;
      pend_sop_q <= pend_sop_d;
      pend_eop_q <= pend_eop_d;
    end
  end

  // Framing flags travel with the RAM word so they stay aligned under backpressure.
  pkt_out_fifo #(
    .Width(DWIDTH + 2)
  ) u_out_fifo (
    .clk_i  (clk_i),
    .srst_i (srst_i),
    .push_i (rd_pend_q),
    .wdata_i({pend_sop_q, pend_eop_q, rddata_i}),
    .pop_i  (xfer),
    .rdata_o(fifo_head),
    .empty_o(fifo_empty),
    .full_o (fifo_full),
    .usedw_o(fifo_usedw)
  );

  assign clr_o    = clr;
  assign rden_o   = rden;
  assign rdaddr_o = issued_q[AWIDTH-1:0];
  assign val_o    = !fifo_empty;
  assign data_o   = fifo_head[DWIDTH-1:0];
  assign sop_o    = fifo_head[DWIDTH+1];
  assign eop_o    = fifo_head[DWIDTH];

endmodule

// File: doc/pkt_rd_ctrl.md
# pkt_rd_ctrl

Read-side controller for the single-packet buffer. It sits directly downstream of the write-address controller. Once the write side reports a complete packet (busy), it reads the stored words from the buffer RAM in address order and streams them out with sop/eop/valid framing under ready backpressure. After the last word is accepted it pulses a clear back to the write side, which releases the buffer.

## Interface
- AWIDTH, 4: buffer address width; the buffer holds 2^AWIDTH words.
- DWIDTH, 16: data word width.

- clk_i  in  1  single clock; all logic on rising edge.
- srst_i  in  1  reset, synchronous, active-high.
- busy_i  in  1  packet-stored flag from the write controller; level signal.
- wrcnt_i  in  AWIDTH  write address from the write controller = stored word count mod 2^AWIDTH.
- clr_o  out  1  one-cycle pulse that clears the write controller (address and busy).
- rden_o  out  1  RAM read enable.
- rdaddr_o  out  AWIDTH  RAM read address.
- rddata_i  in  DWIDTH  RAM read data; valid exactly 1 cycle after rden_o.
- data_o  out  DWIDTH  output word.
- val_o  out  1  output word valid.
- sop_o  out  1  first word of packet; qualified by val_o.
- eop_o  out  1  last word of packet; qualified by val_o.
- ready_i  in  1  downstream accepts; a transfer occurs on val_o & ready_i.

## Operation
- FSM states: IDLE, READ, CLR.
- IDLE:
  - When busy_i=1, latch len = wrcnt_i (0 means 2^AWIDTH words).
  - Clear the issue counter and the transfer counter, then go to READ.
- READ:
  - Issues reads at addresses 0..len-1, in order, at most one per cycle.
  - rden_o=1 when issued<len and credit is available. Credit: output-buffer occupancy + in-flight read ≤ 1, or = 2 with a transfer this cycle.
  - rdaddr_o = issued count; it holds its value while rden_o=0.
  - The RAM word is written into a 2-entry output FIFO the cycle after rden_o.
  - val_o = FIFO not empty; data_o = FIFO head.
  - sop_o=1 on transfer index 0; eop_o=1 on transfer index len-1.
  - On the transfer with eop_o=1, go to CLR.
- CLR: clr_o=1 for exactly this cycle, then go to IDLE. The write controller drops busy_i on the following cycle, so IDLE never re-triggers on a stale busy_i.
- Counters are AWIDTH+1 bits wide so a full-buffer packet (2^AWIDTH words) is counted without wrap.
- Reset values: state IDLE; FIFO empty; clr_o, rden_o, val_o, sop_o, eop_o all 0; rdaddr_o 0; data_o 0.
- Reset mid-packet aborts immediately. No clr_o is issued, because the write side is reset by the same srst_i.
- busy_i falling while in READ is ignored; the packet completes using the latched len.
- While val_o=1 and ready_i=0: data_o, sop_o and eop_o stay stable, and no word is lost or duplicated.

## Timing
- Cycle 0: busy_i first high in IDLE. Cycle 1: rden_o=1, rdaddr_o=0. Cycle 2: rddata_i valid. Cycle 3: val_o=1, sop_o=1.
- With ready_i held high, output is 1 word/cycle. The last transfer is in cycle len+2; clr_o is high in cycle len+3; earliest next busy_i detection is cycle len+5.
- Minimum idle between packets is set by the write side; this block accepts a new busy_i in any IDLE cycle.
- Output data has no combinational path from rddata_i. ready_i may combinationally affect rden_o only.

## Structure
- Shared package pkt_buf_pkg: state enum (IDLE, READ, CLR); default widths AWIDTH/DWIDTH as localparams shared with the write controller.
- Sub-module pkt_out_fifo: 2-entry synchronous FIFO (DWIDTH+2 bits wide, carrying sop/eop). It provides push, pop, empty, full and a usedw count used for the credit calculation.
- Top level: FSM, len latch, issue and transfer counters, credit logic.

## Test plan
- len=5, ready_i=1: words 0..4 appear in cycles 3..7, sop on cycle 3, eop on cycle 7; clr_o one pulse in cycle 8; exactly 5 rden_o pulses.
- len=1: a single word with sop_o=eop_o=1; clr_o one cycle after the handshake.
- wrcnt_i=0 with AWIDTH=4: 16 words from addresses 0..15, eop on word 15, no counter wrap.
- ready_i toggling 1,0,0,1 (pseudo-random) over len=8: output equals RAM contents 0..7 in order, no duplicates or drops. FIFO never overflows, i.e. no rden_o issued without credit.
- srst_i asserted for 1 cycle during word 3 of 8: next cycle all outputs 0, state IDLE, no clr_o. A new busy_i restarts at address 0 with sop_o.
- busy_i deasserted mid-READ with len=6: all 6 words still delivered, clr_o pulsed once.
